// File: rtl/sram_axi4_burst.sv
// AXI4 slave SRAM: FIXED/INCR/WRAP bursts, narrow transfers, byte strobes, independent R/W channels.
// Optional SRAM_AXI4_DECERR_EN: beats above the array return DECERR instead of aliasing.
module sram_axi4_burst #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ID_W   = 4
) (
    input  logic                i_aclk,
    input  logic                i_areset_n,
    input  logic [ID_W-1:0]     i_arid,
    input  logic [ADDR_W-1:0]   i_araddr,
    input  logic [7:0]          i_arlen,
    input  logic [2:0]          i_arsize,
    input  logic [1:0]          i_arburst,
    input  logic                i_arvalid,
    output logic                o_arready,
    output logic [ID_W-1:0]     o_rid,
    output logic [DATA_W-1:0]   o_rdata,
    output logic [1:0]          o_rresp,
    output logic                o_rlast,
    output logic                o_rvalid,
    input  logic                i_rready,
    input  logic [ID_W-1:0]     i_awid,
    input  logic [ADDR_W-1:0]   i_awaddr,
    input  logic [7:0]          i_awlen,
    input  logic [2:0]          i_awsize,
    input  logic [1:0]          i_awburst,
    input  logic                i_awvalid,
    output logic                o_awready,
    input  logic [DATA_W-1:0]   i_wdata,
    input  logic [DATA_W/8-1:0] i_wstrb,
    input  logic                i_wlast,
    input  logic                i_wvalid,
    output logic                o_wready,
    output logic [ID_W-1:0]     o_bid,
    output logic [1:0]          o_bresp,
    output logic                o_bvalid,
    input  logic                i_bready
);
    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned LOG_B = $clog2(BYTES);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef enum logic {R_IDLE, R_DATA} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

    function automatic logic [ADDR_W-1:0] f_next(input logic [ADDR_W-1:0] addr,
                                                 input logic [7:0] len, input logic [2:0] size,
                                                 input logic [1:0] burst);
        logic [ADDR_W-1:0] step;
        logic [ADDR_W-1:0] mask;
        step = ADDR_W'(1) << size;
        mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        case (burst)
            2'b00:   return addr;
            2'b10:   return (addr & ~mask) | ((addr + step) & mask);
            default: return addr + step;
        endcase
    endfunction

    function automatic logic f_cfg_err(input logic [7:0] len, input logic [2:0] size,
                                       input logic [1:0] burst);
        logic wrap_ok;
        wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (32'(size) > LOG_B) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_ok);
    endfunction

    function automatic logic [IDX_W-1:0] f_idx(input logic [ADDR_W-1:0] addr);
        return addr[LOG_B +: IDX_W];
    endfunction

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Read channel state
    rstate_t           r_rstate;
    logic [ADDR_W-1:0] r_ar_addr;
    logic [7:0]        r_ar_len;
    logic [2:0]        r_ar_size;
    logic [1:0]        r_ar_burst;
    logic              r_ar_err;
    logic [7:0]        r_rcnt;
    logic              r_arready;
    logic              r_rvalid;
    logic              r_rlast;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_rresp;
    logic [ID_W-1:0]   r_rid;

    // Write channel state
    wstate_t           r_wstate;
    logic [ADDR_W-1:0] r_aw_addr;
    logic [7:0]        r_aw_len;
    logic [2:0]        r_aw_size;
    logic [1:0]        r_aw_burst;
    logic              r_aw_err;
    logic [7:0]        r_wcnt;
    logic [1:0]        r_w_acc;
    logic              r_awready;
    logic              r_wready;
    logic              r_bvalid;
    logic [1:0]        r_bresp;
    logic [ID_W-1:0]   r_bid;

    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_rd_err;
    logic              w_rd_last;
    logic              w_rd_dec;
    logic [DATA_W-1:0] w_rd_data;
    logic [1:0]        w_rd_resp;
    logic              w_wr_dec;
    logic              w_wbeat;
    logic              w_we;
    logic              w_w_is_last;
    logic [IDX_W-1:0]  w_widx;
    logic [1:0]        w_bresp_nxt;

    // Address of the beat loaded into the R output register on the next edge
    always_comb begin
        if (r_rstate == R_IDLE) begin
            w_rd_addr = i_araddr;
            w_rd_err  = f_cfg_err(i_arlen, i_arsize, i_arburst);
            w_rd_last = (i_arlen == 8'd0);
        end else begin
            w_rd_addr = f_next(r_ar_addr, r_ar_len, r_ar_size, r_ar_burst);
            w_rd_err  = r_ar_err;
            w_rd_last = ((r_rcnt + 8'd1) == r_ar_len);
        end
    end

`ifdef SRAM_AXI4_DECERR_EN
    localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W+1)'(DEPTH * BYTES);
    assign w_rd_dec = ({1'b0, w_rd_addr} >= MEM_BYTES);
    assign w_wr_dec = ({1'b0, r_aw_addr} >= MEM_BYTES);
`else
    assign w_rd_dec = 1'b0;
    assign w_wr_dec = 1'b0;
`endif

    assign w_rd_data   = (w_rd_err || w_rd_dec) ? '0 : r_mem[f_idx(w_rd_addr)];
    assign w_rd_resp   = w_rd_dec ? 2'b11 : (w_rd_err ? 2'b10 : 2'b00);
    assign w_wbeat     = r_wready && i_wvalid;
    assign w_we        = w_wbeat && !r_aw_err && !w_wr_dec;
    assign w_widx      = f_idx(r_aw_addr);
    assign w_w_is_last = (r_wcnt == r_aw_len);

    always_comb begin
        w_bresp_nxt = r_w_acc;
        if ((i_wlast != w_w_is_last) && (w_bresp_nxt == 2'b00)) w_bresp_nxt = 2'b10;
        if (w_wr_dec) w_bresp_nxt = 2'b11;
    end

    // Non-blocking write keeps a same-edge read on the old word
    always_ff @(posedge i_aclk) begin
        if (w_we) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (i_wstrb[b]) r_mem[w_widx][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_rstate   <= R_IDLE;
            r_ar_addr  <= '0;
            r_ar_len   <= '0;
            r_ar_size  <= '0;
            r_ar_burst <= '0;
            r_ar_err   <= 1'b0;
            r_rcnt     <= '0;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rlast    <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= '0;
            r_rid      <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    r_arready <= 1'b1;
                    if (i_arvalid && r_arready) begin
                        r_ar_addr  <= i_araddr;
                        r_ar_len   <= i_arlen;
                        r_ar_size  <= i_arsize;
                        r_ar_burst <= i_arburst;
                        r_ar_err   <= w_rd_err;
                        r_rid      <= i_arid;
                        r_rcnt     <= '0;
                        r_arready  <= 1'b0;
                        r_rvalid   <= 1'b1;
                        r_rdata    <= w_rd_data;
                        r_rresp    <= w_rd_resp;
                        r_rlast    <= w_rd_last;
                        r_rstate   <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (i_rready) begin
                        if (r_rlast) begin
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_rdata   <= '0;
                            r_rresp   <= '0;
                            r_arready <= 1'b1;
                            r_rstate  <= R_IDLE;
                        end else begin
                            r_rcnt    <= r_rcnt + 8'd1;
                            r_ar_addr <= w_rd_addr;
                            r_rdata   <= w_rd_data;
                            r_rresp   <= w_rd_resp;
                            r_rlast   <= w_rd_last;
                        end
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_wstate   <= W_IDLE;
            r_aw_addr  <= '0;
            r_aw_len   <= '0;
            r_aw_size  <= '0;
            r_aw_burst <= '0;
            r_aw_err   <= 1'b0;
            r_wcnt     <= '0;
            r_w_acc    <= '0;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= '0;
            r_bid      <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    r_awready <= 1'b1;
                    if (i_awvalid && r_awready) begin
                        r_aw_addr  <= i_awaddr;
                        r_aw_len   <= i_awlen;
                        r_aw_size  <= i_awsize;
                        r_aw_burst <= i_awburst;
                        r_aw_err   <= f_cfg_err(i_awlen, i_awsize, i_awburst);
                        r_w_acc    <= f_cfg_err(i_awlen, i_awsize, i_awburst) ? 2'b10 : 2'b00;
                        r_bid      <= i_awid;
                        r_wcnt     <= '0;
                        r_awready  <= 1'b0;
                        r_wready   <= 1'b1;
                        r_wstate   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (i_wvalid) begin
                        r_w_acc   <= w_bresp_nxt;
                        r_aw_addr <= f_next(r_aw_addr, r_aw_len, r_aw_size, r_aw_burst);
                        r_wcnt    <= r_wcnt + 8'd1;
                        if (w_w_is_last) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bresp  <= w_bresp_nxt;
                            r_wstate <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (i_bready) begin
                        r_bvalid  <= 1'b0;
                        r_bresp   <= '0;
                        r_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    assign o_arready = r_arready;
    assign o_rid     = r_rid;
    assign o_rdata   = r_rdata;
    assign o_rresp   = r_rresp;
    assign o_rlast   = r_rlast;
    assign o_rvalid  = r_rvalid;
    assign o_awready = r_awready;
    assign o_wready  = r_wready;
    assign o_bid     = r_bid;
    assign o_bresp   = r_bresp;
    assign o_bvalid  = r_bvalid;

endmodule
